alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single execution-stage ALU between two requesters (req 0 = main issue path, req 1 = auxiliary/address path).
- Round-robin arbitration with valid/ready handshakes on both sides.
- The ALU itself is external and combinational. This block drives its operands and opcode, then registers result and flags into a one-entry response slot tagged with the requester id.
- Sits between decode/issue and the execution stage. Latency is 1 cycle from grant to response.

Parameters:
- DATA_W, 64, operand/result width.
- OP_W, 8, ALU opcode width.
- FLAG_W, 4, flag width; order is n, z, c, v.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- req_valid  in  [0:1]  request valid per requester.
- req_ready  out  [0:1]  request accepted this cycle, per requester.
- req0_operand_a, req1_operand_a  in  [0:DATA_W-1]  operand A per requester.
- req0_operand_b, req1_operand_b  in  [0:DATA_W-1]  operand B per requester.
- req0_aluop, req1_aluop  in  [0:OP_W-1]  opcode per requester.
- alu_a, alu_b  out  [0:DATA_W-1]  operands driven to ALU.
- alu_op  out  [0:OP_W-1]  opcode driven to ALU.
- alu_y  in  [0:DATA_W-1]  ALU result, combinational from alu_a/alu_b/alu_op.
- alu_flags  in  [0:FLAG_W-1]  ALU flags n, z, c, v.
- resp_valid  out  1  response slot holds a result.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester that owns the response.
- resp_result  out  [0:DATA_W-1]  registered ALU result.
- resp_flags  out  [0:FLAG_W-1]  registered flags.

Behaviour:
- Reset (n_rst low, async):
  - resp_valid=0, resp_id=0, resp_result=0, resp_flags=0.
  - Priority pointer prio=0 (requester 0 wins the first tie).
  - req_ready=0 while reset is asserted.
- Slot free condition: slot_free = !resp_valid || resp_ready.
- Grant logic (combinational):
  - When slot_free is low, no grant.
  - When only one req_valid is high, that requester is granted.
  - When both are high, requester prio is granted.
- req_ready[i] = grant[i]. Exactly one bit or none is high, never both. req_ready may depend combinationally on req_valid; requesters must not make req_valid depend on req_ready.
- ALU drive:
  - alu_a/alu_b/alu_op are muxed from the granted requester.
  - With no grant, they are muxed from the requester indicated by prio, to keep toggling deterministic.
- On a grant at edge N:
  - Edge N loads resp_result<=alu_y, resp_flags<=alu_flags, resp_id<=granted index, resp_valid<=1.
  - prio<=~granted index.
- Drain only (resp_valid && resp_ready, no grant): resp_valid<=0. Data registers hold their last values.
- Drain and grant in the same cycle: the new response replaces the old one with no bubble. Throughput is 1 op/cycle.
- Back-pressure (resp_valid && !resp_ready): no grants. All resp_* outputs are held stable.
- Fairness: with both requesters continuously valid and resp_ready=1, grants alternate 0,1,0,1,…. A waiting requester is granted within 2 grant opportunities.
- prio updates only on a grant. Idle cycles do not change it.
- Reset mid-operation: any pending response is discarded. An unaccepted request is not granted and its requester must keep it presented.
- Opcodes are passed through unchecked. Flags and result come only from the ALU.

Decomposition:
- Package alu_arb_pkg:
  - DATA_W, OP_W, FLAG_W constants.
  - typedef req_id_t (1 bit).
  - Flag index constants FLAG_N=0, FLAG_Z=1, FLAG_C=2, FLAG_V=3.
  - Struct alu_req_t {operand_a, operand_b, aluop}.
- One sub-module, rr_arbiter2: 2-way round-robin with inputs req[0:1], en, clk, n_rst and output grant[0:1]. It holds prio internally.
- The top holds the operand mux and the response slot.

Test Plan:
- ALU stub is y=a+b, flags computed from y. Setup: reset, resp_ready=1, req 0 only: a=5, b=7. Response: req_ready[0]=1 that cycle; next cycle resp_valid=1, resp_id=0, resp_result=12, z=0.
- Both valid continuously for 4 cycles, req0 a=1, b=1 and req1 a=2, b=2. Responses arrive in order id 0,1,0,1 with results 2,4,2,4; req_ready never 2'b11.
- After a response lands, hold resp_ready=0 for 3 cycles with both valid. Outputs are held stable and req_ready=0; on release a grant happens the same cycle and the slot reloads with no bubble.
- Zero result: req 1 with a=0, b=0. resp_result=0, resp_flags[z]=1, resp_id=1.
- Reset mid-operation: assert n_rst low asynchronously while resp_valid=1. resp_valid drops without waiting for a clock edge; after release, the first tie goes to requester 0.
- Single requester streaming: req 1 valid for 5 cycles with resp_ready=1. Granted every cycle, 5 responses, prio ends at 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the execution-stage ALU arbiter.
package alu_arb_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned N_REQ  = 2;

    // Flag bit positions within alu_flags / resp_flags.
    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

    typedef logic req_id_t;

    typedef struct packed {
        logic [DATA_W-1:0] operand_a;
        logic [DATA_W-1:0] operand_b;
        logic [OP_W-1:0]   aluop;
    } alu_req_t;

    // Index of a one-hot (or empty) two-way grant vector.
    function automatic req_id_t grant_index(input logic [N_REQ-1:0] grant);
        return req_id_t'(grant[1]);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; prio names the requester that wins the next tie.
module rr_arbiter2
    import alu_arb_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             prio
);

    always_comb begin
        grant = '0;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    // The winner hands priority to the other requester; idle cycles leave it alone.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prio <= 1'b0;
        end else if (|grant) begin
            prio <= ~grant_index(grant);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the issue and address paths and
// captures each result into a single tagged response slot.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  req_ready,
    input  logic [DATA_W-1:0] req0_operand_a,
    input  logic [DATA_W-1:0] req1_operand_a,
    input  logic [DATA_W-1:0] req0_operand_b,
    input  logic [DATA_W-1:0] req1_operand_b,
    input  logic [OP_W-1:0]   req0_aluop,
    input  logic [OP_W-1:0]   req1_aluop,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic [FLAG_W-1:0] resp_flags
);

    logic             slot_free_c;
    logic             arb_en_c;
    logic [N_REQ-1:0] grant_c;
    logic             prio;
    req_id_t          sel_id_c;
    alu_req_t         req0_c;
    alu_req_t         req1_c;
    alu_req_t         sel_c;

    // Slot can take a new result if empty or being drained this cycle;
    // nothing is granted while reset is held.
    assign slot_free_c = !resp_valid || resp_ready;
    assign arb_en_c    = slot_free_c && n_rst;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (arb_en_c),
        .req   (req_valid),
        .grant (grant_c),
        .prio  (prio)
    );

    assign req_ready = grant_c;

    assign req0_c = '{operand_a: req0_operand_a, operand_b: req0_operand_b, aluop: req0_aluop};
    assign req1_c = '{operand_a: req1_operand_a, operand_b: req1_operand_b, aluop: req1_aluop};

    // Idle cycles follow prio so the ALU inputs stay deterministic.
    always_comb begin
        sel_id_c = prio;
        if (|grant_c) begin
            sel_id_c = grant_index(grant_c);
        end
        sel_c = sel_id_c ? req1_c : req0_c;
    end

    assign alu_a  = sel_c.operand_a;
    assign alu_b  = sel_c.operand_b;
    assign alu_op = sel_c.aluop;

    // Response slot: a grant overwrites (no bubble); a bare drain only clears valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else if (|grant_c) begin
            resp_valid  <= 1'b1;
            resp_id     <= grant_index(grant_c);
            resp_result <= alu_y;
            resp_flags  <= alu_flags;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule
